// File: rtl/muntjac_ptw_arbiter.sv
// Page-table-walker arbiter: shares one TileLink A/D channel pair between the
// D-side (walker 0) and I-side (walker 1) PTE fetchers. Each walker may have
// one Get outstanding. D beats are routed back by source ID. Beats that match
// no outstanding walker are dropped and flagged on stray_o.
// Optional build macro MUNTJAC_PTW_ARB_RR_EN: round-robin arbitration instead
// of fixed D-side priority.
module muntjac_ptw_arbiter #(
  parameter int unsigned PhysAddrLen = 56,
  parameter int unsigned SourceWidth = 4,
  parameter int unsigned DSourceBase = 2,
  parameter int unsigned ISourceBase = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [1:0]                  req_valid_i,
  output logic [1:0]                  req_ready_o,
  input  logic [1:0][PhysAddrLen-1:0] req_addr_i,
  output logic [1:0]                  resp_valid_o,
  input  logic [1:0]                  resp_ready_i,
  output logic [63:0]                 resp_data_o,
  output logic                        resp_denied_o,
  output logic                        a_valid_o,
  input  logic                        a_ready_i,
  output logic [PhysAddrLen-1:0]      a_address_o,
  output logic [SourceWidth-1:0]      a_source_o,
  input  logic                        d_valid_i,
  output logic                        d_ready_o,
  input  logic [SourceWidth-1:0]      d_source_i,
  input  logic [63:0]                 d_data_i,
  input  logic                        d_denied_i,
  output logic                        stray_o
);

  localparam logic [SourceWidth-1:0] DSrc = SourceWidth'(DSourceBase);
  localparam logic [SourceWidth-1:0] ISrc = SourceWidth'(ISourceBase);

  logic [1:0]             busy;
  logic                   gnt_q;
  logic                   gnt_idx_q;
  logic [PhysAddrLen-1:0] gnt_addr_q;
  logic [1:0]             elig;
  logic                   arb_idx;
  logic                   sel_idx;
  logic                   a_fire;
  logic [1:0]             a_set;
  logic [1:0]             d_hit;
  logic [1:0]             d_clr;

  assign elig = req_valid_i & ~busy;

`ifdef MUNTJAC_PTW_ARB_RR_EN
  // Walker preferred on the next contention; the last winner loses the next tie.
  logic prio_q;

  // Round-robin pick between eligible walkers.
  always_comb begin
    arb_idx = 1'b0;
    if (elig == 2'b11) arb_idx = prio_q;
    else               arb_idx = ~elig[0];
  end

  // Hand priority to the other walker after every A fire.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       prio_q <= 1'b0;
    else if (a_fire) prio_q <= ~sel_idx;
  end
`else
  // Fixed priority: D-side wins whenever it is eligible.
  always_comb begin
    arb_idx = ~elig[0];
  end
`endif

  // A channel: a latched grant overrides fresh arbitration so the request stays stable.
  always_comb begin
    sel_idx     = gnt_q ? gnt_idx_q : arb_idx;
    a_valid_o   = ~rst_i & (gnt_q | (|elig));
    a_address_o = gnt_q ? gnt_addr_q : req_addr_i[arb_idx];
    a_source_o  = sel_idx ? ISrc : DSrc;
    a_fire      = a_valid_o & a_ready_i;
    a_set       = 2'b00;
    if (a_fire) a_set[sel_idx] = 1'b1;
    req_ready_o = a_set;
  end

  // D channel: route a beat to its walker only while that walker is waiting.
  always_comb begin
    d_hit[0]      = busy[0] & (d_source_i == DSrc);
    d_hit[1]      = busy[1] & (d_source_i == ISrc) & ~d_hit[0];
    resp_valid_o  = {2{d_valid_i & ~rst_i}} & d_hit;
    d_ready_o     = d_hit[0] ? resp_ready_i[0] :
                    d_hit[1] ? resp_ready_i[1] : 1'b1;
    stray_o       = d_valid_i & ~rst_i & ~(|d_hit);
    d_clr         = resp_valid_o & resp_ready_i;
    resp_data_o   = d_data_i;
    resp_denied_o = d_denied_i;
  end

  // Outstanding tracking and grant latch; an A set and a D clear never hit the same walker.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy       <= 2'b00;
      gnt_q      <= 1'b0;
      gnt_idx_q  <= 1'b0;
      gnt_addr_q <= '0;
    end else begin
      busy <= (busy | a_set) & ~d_clr;
      if (a_fire) begin
        gnt_q <= 1'b0;
      end else if (a_valid_o && !gnt_q) begin
        gnt_q      <= 1'b1;
        gnt_idx_q  <= arb_idx;
        gnt_addr_q <= req_addr_i[arb_idx];
      end
    end
  end

endmodule

// File: tb/tb_muntjac_ptw_arbiter.sv
// Bench for muntjac_ptw_arbiter: D-channel routing vector tables, an A-fire
// scoreboard, and hand sequences for grant hold, back-pressure, arbitration
// and asynchronous reset. Honours MUNTJAC_PTW_ARB_RR_EN like the design.
module tb_muntjac_ptw_arbiter;

`ifdef MUNTJAC_PTW_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [55:0] A0 = 56'h12_3456_7800;
  localparam logic [55:0] A1 = 56'hAB_CDEF_0008;
  localparam logic [55:0] A2 = 56'h00_0FED_CBA0;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid, req_ready, resp_valid, resp_ready;
  logic [1:0][55:0] req_addr;
  logic [63:0]      resp_data, d_data;
  logic             resp_denied, a_valid, a_ready, d_valid, d_ready, d_denied, stray;
  logic [55:0]      a_address;
  logic [3:0]       a_source, d_source;

  always #5 clk = ~clk;

  muntjac_ptw_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_data_o(resp_data), .resp_denied_o(resp_denied),
    .a_valid_o(a_valid), .a_ready_i(a_ready), .a_address_o(a_address), .a_source_o(a_source),
    .d_valid_i(d_valid), .d_ready_o(d_ready), .d_source_i(d_source),
    .d_data_i(d_data), .d_denied_i(d_denied), .stray_o(stray)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic [3:0] src; logic [55:0] addr; } afire_t;
  afire_t sb[$];

  typedef struct {
    logic [3:0] src;
    logic       idle_dr; logic [1:0] idle_rv; logic idle_st;
    logic       busy_dr; logic [1:0] busy_rv; logic busy_st;
  } dvec_t;
  dvec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // Scoreboard: every A fire must match the oldest expected {source, address}.
  always @(negedge clk) begin : a_mon
    afire_t e;
    if (!rst && a_valid && a_ready) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_fire_unexpected: got source %0d, expected no fire", a_source);
      end else begin
        e = sb.pop_front();
        chk("a_fire_src", 64'(a_source), 64'(e.src));
        chk("a_fire_addr", 64'(a_address), 64'(e.addr));
      end
    end
  end

  task automatic d_beat(input logic [3:0] src, input logic [1:0] exp_rv);
    d_valid = 1'b1; d_source = src; resp_ready = 2'b11;
    samp();
    chk("d_route", 64'(resp_valid), 64'(exp_rv));
    tick();
    d_valid = 1'b0; resp_ready = 2'b00;
  endtask

  // Issue both walkers together (D then I) with a_ready high; leaves both busy.
  task automatic issue_both();
    req_valid = 2'b11; a_ready = 1'b1;
    sb.push_back('{4'd2, A0}); sb.push_back('{4'd3, A1});
    samp(); chk("issue_rdy_d", 64'(req_ready), 64'(2'b01));
    tick(); req_valid = 2'b10;
    samp(); chk("issue_rdy_i", 64'(req_ready), 64'(2'b10));
    tick(); req_valid = 2'b00; a_ready = 1'b0;
  endtask

  task automatic run_table(input bit busy_state);
    for (int i = 0; i < 5; i++) begin
      d_valid = 1'b1; d_source = vecs[i].src; resp_ready = 2'b00;
      samp();
      chk("tbl_d_ready",    64'(d_ready),    64'(busy_state ? vecs[i].busy_dr : vecs[i].idle_dr));
      chk("tbl_resp_valid", 64'(resp_valid), 64'(busy_state ? vecs[i].busy_rv : vecs[i].idle_rv));
      chk("tbl_stray",      64'(stray),      64'(busy_state ? vecs[i].busy_st : vecs[i].idle_st));
      tick();
    end
    d_valid = 1'b0;
    samp(); chk("stray_pulse_end", 64'(stray), 64'(1'b0));
    tick();
  endtask

  int sched[16];

  initial begin
    vecs[0] = '{4'd2,  1'b1, 2'b00, 1'b1,  1'b0, 2'b01, 1'b0};
    vecs[1] = '{4'd3,  1'b1, 2'b00, 1'b1,  1'b0, 2'b10, 1'b0};
    vecs[2] = '{4'd5,  1'b1, 2'b00, 1'b1,  1'b1, 2'b00, 1'b1};
    vecs[3] = '{4'd0,  1'b1, 2'b00, 1'b1,  1'b1, 2'b00, 1'b1};
    vecs[4] = '{4'd15, 1'b1, 2'b00, 1'b1,  1'b1, 2'b00, 1'b1};

    // Reset: outputs forced quiet even with live inputs.
    rst = 1'b1; req_valid = 2'b11; req_addr[0] = A0; req_addr[1] = A1;
    resp_ready = 2'b11; a_ready = 1'b1;
    d_valid = 1'b1; d_source = 4'd2; d_data = '0; d_denied = 1'b0;
    samp();
    chk("rst_a_valid",    64'(a_valid),    64'(1'b0));
    chk("rst_req_ready",  64'(req_ready),  64'(2'b00));
    chk("rst_resp_valid", 64'(resp_valid), 64'(2'b00));
    chk("rst_stray",      64'(stray),      64'(1'b0));
    tick();
    req_valid = 2'b00; resp_ready = 2'b00; a_ready = 1'b0; d_valid = 1'b0;
    tick(); rst = 1'b0;

    // Every D beat is stray while nothing is outstanding.
    run_table(1'b0);

    // D-side wins first, I-side next cycle.
    issue_both();

    // Both busy: beats route by source without firing (resp_ready low).
    run_table(1'b1);

    // Back-pressure on walker 1 holds the beat, then delivers it to walker 1 only.
    d_valid = 1'b1; d_source = 4'd3; d_data = 64'h0000_0000_2000_0001; d_denied = 1'b0;
    resp_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      samp();
      chk("bp_d_ready",    64'(d_ready),    64'(1'b0));
      chk("bp_resp_valid", 64'(resp_valid), 64'(2'b10));
      tick();
    end
    resp_ready = 2'b10;
    samp();
    chk("bp_deliver_valid", 64'(resp_valid), 64'(2'b10));
    chk("bp_deliver_ready", 64'(d_ready),    64'(1'b1));
    chk("bp_deliver_data",  resp_data,       64'h0000_0000_2000_0001);
    tick();
    resp_ready = 2'b00; d_source = 4'd3;
    samp(); chk("bp_after_stray", 64'(stray), 64'(1'b1));
    tick(); d_valid = 1'b0;
    d_beat(4'd2, 2'b01);

    // Grant held for 3 cycles of a_ready low, regardless of the I-side arriving.
    req_addr[0] = A2; req_valid = 2'b01; a_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      samp();
      chk("hold_a_valid", 64'(a_valid),   64'(1'b1));
      chk("hold_addr",    64'(a_address), 64'(A2));
      chk("hold_src",     64'(a_source),  64'(4'd2));
      chk("hold_rdy",     64'(req_ready), 64'(2'b00));
      tick();
      req_valid = 2'b11;
    end
    a_ready = 1'b1;
    sb.push_back('{4'd2, A2}); sb.push_back('{4'd3, A1});
    samp(); chk("hold_release_rdy", 64'(req_ready), 64'(2'b01));
    tick(); req_valid = 2'b10;
    samp(); tick(); req_valid = 2'b00; a_ready = 1'b0;
    req_addr[0] = A0;
    d_beat(4'd2, 2'b01);
    d_beat(4'd3, 2'b10);

    // Contention after a D-side win: RR hands it to I, fixed priority keeps D.
    req_valid = 2'b01; a_ready = 1'b1; sb.push_back('{4'd2, A0});
    samp(); tick(); req_valid = 2'b00; a_ready = 1'b0;
    d_beat(4'd2, 2'b01);
    req_valid = 2'b11; a_ready = 1'b1;
    if (RR) begin sb.push_back('{4'd3, A1}); sb.push_back('{4'd2, A0}); end
    else    begin sb.push_back('{4'd2, A0}); sb.push_back('{4'd3, A1}); end
    samp(); chk("contend_rdy", 64'(req_ready), 64'(RR ? 2'b10 : 2'b01));
    tick(); req_valid = RR ? 2'b01 : 2'b10;
    samp(); tick(); req_valid = 2'b00; a_ready = 1'b0;
    d_beat(4'd2, 2'b01);
    d_beat(4'd3, 2'b10);

    // Continuous requests, each response 2 cycles after its grant: D,I,D,I,D,I.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 16; i++) sched[i] = -1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{4'd2, A0}); sb.push_back('{4'd3, A1});
    end
    a_ready = 1'b1;
    for (int cyc = 0; cyc < 11; cyc++) begin
      req_valid = (cyc < 8) ? 2'b11 : 2'b00;
      if (sched[cyc] >= 0) begin
        d_valid = 1'b1; d_source = 4'(sched[cyc]); resp_ready = 2'b11;
      end else begin
        d_valid = 1'b0; resp_ready = 2'b00;
      end
      samp();
      if (a_valid && a_ready && cyc + 2 < 16) sched[cyc+2] = int'(a_source);
      tick();
    end
    d_valid = 1'b0; req_valid = 2'b00; a_ready = 1'b0; resp_ready = 2'b00;
    chk("continuous_drained", 64'(sb.size()), 64'(0));

    // Asynchronous reset with both walkers busy; old beats become stray.
    issue_both();
    #1; d_valid = 1'b1; d_source = 4'd2;
    #1; chk("pre_rst_route", 64'(resp_valid), 64'(2'b01));
    rst = 1'b1;
    #1; chk("in_rst_resp_valid", 64'(resp_valid), 64'(2'b00));
    chk("in_rst_stray", 64'(stray), 64'(1'b0));
    rst = 1'b0;
    #1;
    chk("post_rst_stray_d",  64'(stray),      64'(1'b1));
    chk("post_rst_ready_d",  64'(d_ready),    64'(1'b1));
    chk("post_rst_valid_d",  64'(resp_valid), 64'(2'b00));
    d_source = 4'd3;
    #1; chk("post_rst_stray_i", 64'(stray), 64'(1'b1));
    tick(); d_valid = 1'b0;
    tick();

    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muntjac_ptw_arbiter.md
MUNTJAC_PTW_ARBITER -- requirements
Module: muntjac_ptw_arbiter

Interface
REQ-001 SHALL have parameter PhysAddrLen, default 56, physical address width.
REQ-002 SHALL have parameter SourceWidth, default 4, TileLink source ID width.
REQ-003 SHALL have parameter DSourceBase, default 2, A-channel source ID for the D-side walker.
REQ-004 SHALL have parameter ISourceBase, default 3, A-channel source ID for the I-side walker.
REQ-005 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port req_valid_i  input  2  walker request valid ([0]=D-side, [1]=I-side).
REQ-008 SHALL have port req_ready_o  output  2  walker request accepted.
REQ-009 SHALL have port req_addr_i  input  2xPhysAddrLen  8-byte PTE address per walker.
REQ-010 SHALL have port resp_valid_o  output  2  PTE response valid per walker.
REQ-011 SHALL have port resp_ready_i  input  2  walker response ready.
REQ-012 SHALL have port resp_data_o  output  64  PTE data, shared by both walkers.
REQ-013 SHALL have port resp_denied_o  output  1  access-fault flag, shared.
REQ-014 SHALL have port a_valid_o / a_ready_i / a_address_o / a_source_o  out/in/out/out  1/1/PhysAddrLen/SourceWidth  shared A channel (Get, size 3, tied outside this block).
REQ-015 SHALL have port d_valid_i / d_ready_o / d_source_i / d_data_i / d_denied_i  in/out/in/in/in  1/1/SourceWidth/64/1  shared D channel.
REQ-016 SHALL have port stray_o  output  1  one-cycle pulse: D beat dropped.

Function
REQ-017 SHALL keep busy[1:0]; walker i is eligible only when req_valid_i[i] and !busy[i].
REQ-018 SHALL, with no grant held, select an eligible walker combinationally, drive a_valid_o=1 with its address and source in the same cycle (zero latency).
REQ-019 SHALL, if a_valid_o=1 and a_ready_i=0, latch the grant; address, source and a_valid_o stay stable until a_ready_i=1, regardless of the other walker.
REQ-020 SHALL assert req_ready_o[i] = granted[i] & a_ready_i; on that A fire set busy[i] and clear the latched grant.
REQ-021 SHALL route D beat with d_source_i==DSourceBase/ISourceBase to walker 0/1 when its busy bit is set: resp_valid_o[i]=d_valid_i, d_ready_o=resp_ready_i[i], data/denied passed through.
REQ-022 SHALL clear busy[i] on the D fire (d_valid_i & d_ready_o) for walker i; walker i becomes eligible again the following cycle, never the same cycle.
REQ-023 SHALL, for a D beat with an unknown source or a source whose busy bit is clear, drive d_ready_o=1, resp_valid_o=0, and pulse stray_o for that cycle.
REQ-024 SHALL allow both walkers to be busy simultaneously (one outstanding each); an A fire and a D fire in the same cycle for different walkers both take effect.

Reset
REQ-025 SHALL, while rst_i=1, clear busy, latched grant and priority pointer (D-side preferred), forcing a_valid_o=0, req_ready_o=0, resp_valid_o=0 and stray_o=0.
REQ-026 SHALL treat D beats for transactions issued before a reset as stray (REQ-023).

Configuration
REQ-027 SHALL, with MUNTJAC_PTW_ARB_RR_EN defined, arbitrate round-robin: the walker granted on the last A fire has the lowest priority next.
REQ-028 SHALL, without MUNTJAC_PTW_ARB_RR_EN, use fixed priority: D-side always wins over I-side; the pointer register is absent.

Verification
REQ-029 SHALL verify: both walkers valid after reset, a_ready_i=1 -> D-side (source 2) fires first, I-side (source 3) next cycle.
REQ-030 SHALL verify: a_ready_i=0 for 3 cycles while grant is held -> a_address_o/a_source_o unchanged across all 3 cycles, req_ready_o=00.
REQ-031 SHALL verify: RR_EN defined, both continuously valid, each response returned after 2 cycles -> grants alternate D,I,D,I; RR_EN undefined -> D wins every contention.
REQ-032 SHALL verify: D beat source 3, data 0x0000_0000_2000_0001, resp_ready_i[1]=0 for 2 cycles -> d_ready_o=0 for 2 cycles, then the beat is delivered to walker 1 only.
REQ-033 SHALL verify: D beat with source 5, or source 2 while busy[0]=0 -> d_ready_o=1, stray_o pulses for 1 cycle, resp_valid_o=00.
REQ-034 SHALL verify: rst_i asserted with both walkers busy -> busy cleared asynchronously; later D beat with source 2 flagged stray.
